// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   rx_state_t          : receiver FSM state encoding
//   PRESC_8/16/32       : legal oversampling ratios
//   PAR_EVEN / PAR_ODD  : PAR_TYP encodings
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Per-bit oversampling counter and 3-sample majority voter.
// Ports:
//   CLK, RST   clock, asynchronous active-low reset
//   rx_s       synchronized serial line
//   en         advance the edge counter this cycle
//   clr        force the edge counter back to 0 (takes priority over en)
//   prescale   latched oversampling ratio P
//   bit_val    2-of-3 majority of the samples at P/2-1, P/2, P/2+1
//   strobe     decision cycle (edge_cnt = P/2+2)
//   last       final oversample of the bit (edge_cnt = P-1)
// -----------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               rx_s,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] prescale,
    output logic               bit_val,
    output logic               strobe,
    output logic               last
);

    logic [PRESC_W-1:0] edge_cnt;
    logic [PRESC_W-1:0] half;
    logic [2:0]         smp;

    assign half = prescale >> 1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            smp      <= 3'b111;
        end else begin
            if (clr) begin
                edge_cnt <= '0;
            end else if (en) begin
                edge_cnt <= last ? '0 : edge_cnt + PRESC_W'(1);
            end
            if (en) begin
                if (edge_cnt == half - PRESC_W'(1)) smp[0] <= rx_s;
                if (edge_cnt == half)               smp[1] <= rx_s;
                if (edge_cnt == half + PRESC_W'(1)) smp[2] <= rx_s;
            end
        end
    end

    assign bit_val = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    assign strobe  = en && (edge_cnt == half + PRESC_W'(2));
    assign last    = en && (edge_cnt == prescale - PRESC_W'(1));

endmodule

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// UART receiver: 2-flop input synchronizer, start-bit detect with glitch
// rejection, majority-voted LSB-first deserializer, optional parity check and
// stop-bit check. Flags are registered one-cycle pulses.
// Ports:
//   CLK, RST          oversampling clock, asynchronous active-low reset
//   RX_IN             serial line (idles high)
//   PAR_EN, PAR_TYP   parity enable, parity type (0 even, 1 odd)
//   Prescale          oversampling ratio (8, 16 or 32)
//   P_DATA            last good received word
//   data_valid        pulse for a clean frame
//   par_err, stp_err  pulses for parity / stop-bit failures
// Optional (macro UART_RX_ERR_CNT_EN):
//   err_cnt_clr                synchronous clear of both error counters
//   par_err_cnt, stp_err_cnt   saturating 8-bit error counters
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | inside start bit, majority low confirms it, high rejects a glitch
// DATA   | shifting in DATA_LENGTH bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit and issuing the frame verdict
// -----------------------------------------------------------------------------
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int PRESC_W     = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RX_IN,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic [PRESC_W-1:0]     Prescale,
`ifdef UART_RX_ERR_CNT_EN
    input  logic                   err_cnt_clr,
    output logic [7:0]             par_err_cnt,
    output logic [7:0]             stp_err_cnt,
`endif
    output logic [DATA_LENGTH-1:0] P_DATA,
    output logic                   data_valid,
    output logic                   par_err,
    output logic                   stp_err
);

    localparam int              BCW      = $clog2(DATA_LENGTH + 1);
    localparam logic [BCW-1:0]  LAST_BIT = BCW'(DATA_LENGTH - 1);

    rx_state_t              state, nxt;
    logic                   sync1, rx_s;
    logic                   par_en_l, par_typ_l;
    logic [PRESC_W-1:0]     presc_l;
    logic [DATA_LENGTH-1:0] shreg;
    logic [BCW-1:0]         bit_cnt;
    logic                   par_fail;
    logic                   bit_val, strobe, last;
    logic                   start_det;
    logic                   dv_set, pe_set, se_set;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= RX_IN;
            rx_s  <= sync1;
        end
    end

    assign start_det = (state == IDLE) && !rx_s;

    // The detection cycle in IDLE is counted as oversample 0 of the start
    // bit, so the counter is already at 1 when START is entered.
    uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
        .CLK      (CLK),
        .RST      (RST),
        .rx_s     (rx_s),
        .en       ((state != IDLE) || !rx_s),
        .clr      (nxt == IDLE),
        .prescale (presc_l),
        .bit_val  (bit_val),
        .strobe   (strobe),
        .last     (last)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (!rx_s) nxt = START;
            START:   if (strobe && bit_val) nxt = IDLE;
                     else if (last)         nxt = DATA;
            DATA:    if (last && (bit_cnt == LAST_BIT)) nxt = par_en_l ? PARITY : STOP;
            PARITY:  if (last) nxt = STOP;
            STOP:    if (strobe) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        dv_set = 1'b0;
        pe_set = 1'b0;
        se_set = 1'b0;
        if ((state == STOP) && strobe) begin
            se_set = !bit_val;
            pe_set = par_fail;
            dv_set = bit_val && !par_fail;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            par_en_l   <= 1'b0;
            par_typ_l  <= PAR_EVEN;
            presc_l    <= PRESC_W'(PRESC_8);
            shreg      <= '0;
            bit_cnt    <= '0;
            par_fail   <= 1'b0;
        end else begin
            data_valid <= dv_set;
            par_err    <= pe_set;
            stp_err    <= se_set;
            if (dv_set) P_DATA <= shreg;
            // Configuration is frozen for the frame from the start edge on.
            if (start_det) begin
                par_en_l  <= PAR_EN;
                par_typ_l <= PAR_TYP;
                presc_l   <= Prescale;
                bit_cnt   <= '0;
                par_fail  <= 1'b0;
            end
            if (state == DATA) begin
                if (strobe) shreg <= {bit_val, shreg[DATA_LENGTH-1:1]};
                if (last)   bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BCW'(1);
            end
            if ((state == PARITY) && strobe)
                par_fail <= bit_val != ((^shreg) ^ (par_typ_l == PAR_ODD));
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
        end else if (err_cnt_clr) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
        end else begin
            if (par_err && (par_err_cnt != 8'hFF)) par_err_cnt <= par_err_cnt + 8'd1;
            if (stp_err && (stp_err_cnt != 8'hFF)) stp_err_cnt <= stp_err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;
    import uart_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       data_valid, par_err, stp_err;
`ifdef UART_RX_ERR_CNT_EN
    logic       err_cnt_clr;
    logic [7:0] par_err_cnt, stp_err_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int dv_n = 0, pe_n = 0, se_n = 0, ovl_n = 0;
    logic [7:0] dv_log [16];

    always #5 CLK = ~CLK;

    uart_rx_core #(.DATA_LENGTH(8), .PRESC_W(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
`ifdef UART_RX_ERR_CNT_EN
        .err_cnt_clr(err_cnt_clr),
        .par_err_cnt(par_err_cnt),
        .stp_err_cnt(stp_err_cnt),
`endif
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always @(posedge CLK) begin
        if (RST)
            assert (Prescale == 6'(PRESC_8) || Prescale == 6'(PRESC_16) || Prescale == 6'(PRESC_32))
                else $error("illegal Prescale %0d", Prescale);
    end

    // Flags are counted per high cycle, so a pulse wider than one cycle shows
    // up as an extra count.
    always @(negedge CLK) begin
        if (data_valid) begin
            if (dv_n < 16) dv_log[dv_n] = P_DATA;
            dv_n++;
        end
        if (par_err) pe_n++;
        if (stp_err) se_n++;
        if (data_valid && (par_err || stp_err)) ovl_n++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame starting at the current negedge. Configuration inputs
    // are scrambled after the start bit to exercise the frame-level latch.
    task automatic send_frame(input logic [7:0] data, input int p, input logic pen,
                              input logic ptyp, input logic pbit, input logic stopb);
        Prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        RX_IN    = 1'b0;
        repeat (p) @(negedge CLK);
        Prescale = (p == PRESC_8) ? 6'(PRESC_32) : 6'(PRESC_8);
        PAR_EN   = ~pen;
        PAR_TYP  = ~ptyp;
        for (int i = 0; i < 8; i++) begin
            RX_IN = data[i];
            repeat (p) @(negedge CLK);
        end
        if (pen) begin
            RX_IN = pbit;
            repeat (p) @(negedge CLK);
        end
        RX_IN    = stopb;
        Prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        repeat (p) @(negedge CLK);
        RX_IN = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    int b_dv, b_pe, b_se, lat;

    task automatic snap();
        b_dv = dv_n;
        b_pe = pe_n;
        b_se = se_n;
    endtask

    initial begin
        RST      = 1'b0;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        PAR_TYP  = PAR_EVEN;
        Prescale = 6'(PRESC_8);
`ifdef UART_RX_ERR_CNT_EN
        err_cnt_clr = 1'b0;
`endif
        idle(4);
        check("rst_pdata", int'(P_DATA), 0);
        check("rst_dv",    int'(data_valid), 0);
        check("rst_pe",    int'(par_err), 0);
        check("rst_se",    int'(stp_err), 0);
        RST = 1'b1;
        idle(4);

        // P=8, no parity, 0xA5, with latency from the edge that samples the fall
        snap();
        lat = -1;
        fork
            send_frame(8'hA5, PRESC_8, 1'b0, PAR_EVEN, 1'b0, 1'b1);
            begin
                @(posedge CLK);
                for (int n = 1; n <= 200; n++) begin
                    @(posedge CLK);
                    #1;
                    if (data_valid) begin
                        lat = n;
                        break;
                    end
                end
            end
        join
        idle(20);
        check("a5_latency", lat, 80);
        check("a5_pdata", int'(P_DATA), 8'hA5);
        check("a5_dv",    dv_n - b_dv, 1);
        check("a5_pe",    pe_n - b_pe, 0);
        check("a5_se",    se_n - b_se, 0);

        // P=16, even parity, 0x3C with wrong parity bit 1
        snap();
        send_frame(8'h3C, PRESC_16, 1'b1, PAR_EVEN, 1'b1, 1'b1);
        idle(40);
        check("3c_pe",    pe_n - b_pe, 1);
        check("3c_dv",    dv_n - b_dv, 0);
        check("3c_se",    se_n - b_se, 0);
        check("3c_pdata", int'(P_DATA), 8'hA5);

        // P=32, odd parity, 0x01 with correct parity 0 and stop bit 0
        snap();
        send_frame(8'h01, PRESC_32, 1'b1, PAR_ODD, 1'b0, 1'b0);
        idle(80);
        check("01_se",    se_n - b_se, 1);
        check("01_pe",    pe_n - b_pe, 0);
        check("01_dv",    dv_n - b_dv, 0);
        check("01_pdata", int'(P_DATA), 8'hA5);

        // 3-cycle glitch at P=16, then 0x55
        snap();
        Prescale = 6'(PRESC_16);
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        idle(3);
        RX_IN = 1'b1;
        idle(40);
        check("glitch_dv", dv_n - b_dv, 0);
        check("glitch_pe", pe_n - b_pe, 0);
        check("glitch_se", se_n - b_se, 0);
        send_frame(8'h55, PRESC_16, 1'b0, PAR_EVEN, 1'b0, 1'b1);
        idle(40);
        check("55_dv",    dv_n - b_dv, 1);
        check("55_pdata", int'(P_DATA), 8'h55);

        // back-to-back frames at P=8
        snap();
        send_frame(8'h12, PRESC_8, 1'b0, PAR_EVEN, 1'b0, 1'b1);
        send_frame(8'h34, PRESC_8, 1'b0, PAR_EVEN, 1'b0, 1'b1);
        idle(20);
        check("b2b_dv", dv_n - b_dv, 2);
        check("b2b_first",  int'(dv_log[b_dv % 16]), 8'h12);
        check("b2b_second", int'(dv_log[(b_dv + 1) % 16]), 8'h34);
        check("b2b_errs", (pe_n - b_pe) + (se_n - b_se), 0);

        // reset during data bit 4, then a normal frame
        fork
            send_frame(8'hFF, PRESC_8, 1'b0, PAR_EVEN, 1'b0, 1'b1);
            begin
                idle(5 * 8 + 3);
                RST = 1'b0;
                idle(3);
                check("mid_rst_pdata", int'(P_DATA), 0);
                check("mid_rst_flags", int'({data_valid, par_err, stp_err}), 0);
                snap();
                RST = 1'b1;
            end
        join
        idle(20);
        check("post_rst_noflags", (dv_n - b_dv) + (pe_n - b_pe) + (se_n - b_se), 0);
        send_frame(8'hFF, PRESC_8, 1'b0, PAR_EVEN, 1'b0, 1'b1);
        idle(20);
        check("ff_dv",    dv_n - b_dv, 1);
        check("ff_pdata", int'(P_DATA), 8'hFF);

`ifdef UART_RX_ERR_CNT_EN
        err_cnt_clr = 1'b1;
        idle(1);
        err_cnt_clr = 1'b0;
        for (int k = 0; k < 300; k++) begin
            send_frame(8'h00, PRESC_8, 1'b0, PAR_EVEN, 1'b0, 1'b0);
            idle(16);
        end
        check("stp_cnt_sat", int'(stp_err_cnt), 255);
        check("par_cnt",     int'(par_err_cnt), 0);
        err_cnt_clr = 1'b1;
        idle(1);
        err_cnt_clr = 1'b0;
        check("stp_cnt_clr", int'(stp_err_cnt), 0);
`endif

        check("no_overlap", ovl_n, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
UART receive core, the counterpart of the UART TX serializer path. It oversamples RX_IN at CLK = Prescale × baud and detects the start bit. It majority-samples each bit and deserializes LSB-first into P_DATA. It checks optional parity and the stop bit, then pulses data_valid to the RX-side data synchronizer and register-file control.

Parameters:
- DATA_LENGTH, 8, number of data bits per frame.
- PRESC_W, 6, width of the Prescale input.

Ports:
- CLK  in  1  oversampling clock.
- RST  in  1  reset, asynchronous, active-low.
- RX_IN  in  1  serial line; idles high.
- PAR_EN  in  1  1 = a parity bit follows the data bits.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- Prescale  in  PRESC_W  oversampling ratio; legal values are 8, 16 and 32.
- P_DATA  out  DATA_LENGTH  last good received word.
- data_valid  out  1  one-cycle pulse when a frame is good.
- par_err  out  1  one-cycle pulse on parity mismatch.
- stp_err  out  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Reset values: P_DATA=0, data_valid=0, par_err=0, stp_err=0; FSM in IDLE; input synchronizer flops = 1.
- RX_IN passes through a 2-flop synchronizer (rx_s). All timing below is relative to rx_s.
- Configuration latch: PAR_EN, PAR_TYP and Prescale are captured on the IDLE→START transition. They are frozen for the whole frame; mid-frame changes are ignored.
- Counters:
  - edge_cnt runs 0..P-1 within each bit (P = latched Prescale) and wraps to 0 at each bit boundary.
  - bit_cnt counts data bits 0..DATA_LENGTH-1.
- Sampling: rx_s is captured at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority, resolved at edge_cnt = P/2+2 (the "decision cycle").
- FSM states and transitions:
  - IDLE: when rx_s=0, go to START with edge_cnt=0.
  - START: at the decision cycle, if the bit is 1 (glitch), go back to IDLE with no flags raised. At P-1, go to DATA.
  - DATA: shift the majority bit into the shift register LSB-first at each decision cycle. At P-1 of bit DATA_LENGTH-1, go to PARITY if PAR_EN=1, else to STOP.
  - PARITY: at the decision cycle, compare against XOR(data) ^ PAR_TYP and record par_fail. At P-1, go to STOP.
  - STOP: at the decision cycle, evaluate the frame:
    - stop bit 0 → stp_err=1;
    - par_fail → par_err=1;
    - both clean → P_DATA <= shift register and data_valid=1.
    - The FSM returns to IDLE on the next cycle, so a back-to-back start edge half a bit later is caught.
- Flag rules:
  - par_err and stp_err may assert together.
  - data_valid never asserts together with either error flag.
  - P_DATA holds its value on any error.
  - Every flag is exactly one CLK cycle wide.
- Latency: data_valid rises 2 (synchronizer) + (1 + DATA_LENGTH + PAR_EN)·P + P/2+2 cycles after the falling RX_IN edge.
- Illegal Prescale values (anything other than 8/16/32): behaviour undefined; flagged by an assertion in the bench only.
- Reset mid-frame: everything returns to reset values immediately; no flag pulses are produced.

Optional Feature:
- Macro: UART_RX_ERR_CNT_EN.
- Defined: adds outputs par_err_cnt[7:0] and stp_err_cnt[7:0]. Each increments on its error pulse and saturates at 255. Both reset to 0, and both clear synchronously when the new input err_cnt_clr is 1; clear wins over a same-cycle increment.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the legal Prescale constants 8, 16, 32;
  - the PAR_EVEN=0 and PAR_ODD=1 encodings.
- Sub-module uart_rx_sampler holds the edge counter and 3-sample majority voter, and emits bit_val plus a decision strobe.
- The FSM, deserializer and checks stay in the top module.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 (stop bit 1) → P_DATA=0xA5, one-cycle data_valid after 2+9·8+6=80 cycles; no error flags.
- Prescale=16, PAR_EN=1, PAR_TYP=0, 0x3C sent with parity bit 1 (wrong) → par_err pulse, no data_valid, P_DATA unchanged.
- Prescale=32, odd parity, 0x01 sent with stop bit 0 → stp_err pulse only.
- Low glitch of 3 cycles on idle line at Prescale=16 → FSM returns to IDLE; no flags; the next valid frame 0x55 is received correctly.
- Two back-to-back frames 0x12, 0x34 with no idle gap at Prescale=8 → two data_valid pulses with P_DATA=0x12 then 0x34.
- RST deasserted→asserted during data bit 4 → all outputs 0; the following frame 0xFF is received normally. With UART_RX_ERR_CNT_EN defined, inject 300 stop errors → stp_err_cnt=255.
